burst_len_tally: RTL

Downstream consumer of the comb-onTransit run/last controller. It counts the controller's `s` (stay) pulses during a run, and closes the run on its `g` (go/last) pulse. Each closed run's length goes into a small FIFO, which is drained over a valid/ready handshake. It turns the controller's per-cycle transition pulses into one length record per burst for later stages.

---
 rtl/burst_len_tally.sv | 131 +++++++++++++
 1 files changed

// File: rtl/burst_len_tally.sv
// Tallies stay pulses per run and queues each closed run's length in a small FIFO.
// Optional drop counter output enabled by defining BURST_LEN_TALLY_DROP_CNT_EN.
module burst_len_tally #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             g,
  input  logic             s,
  output logic             len_valid,
  input  logic             len_ready,
  output logic [CNT_W-1:0] len_data,
  output logic             len_sat,
  output logic             busy,
  output logic             full,
  output logic             drop_pulse
`ifdef BURST_LEN_TALLY_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e           state_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;

  logic [CNT_W:0]   mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d, occ_rem;
  logic             len_valid_q;
  logic [CNT_W-1:0] len_data_q;
  logic             len_sat_q;
  logic             full_q;
  logic             drop_pulse_q;

  logic [CNT_W-1:0] entry_len;
  logic             entry_sat;
  logic             pop, push;
  logic [CNT_W:0]   head_d;

  always_comb begin
    entry_sat = (cnt_q == CNT_MAX);
    entry_len = entry_sat ? CNT_MAX : cnt_q + 1'b1;
    pop       = len_valid_q && len_ready;
    // A full FIFO still accepts the run if the head leaves in the same cycle.
    push      = g && (!full_q || pop);
    occ_rem   = occ_q - OW'(pop);
    occ_d     = occ_rem + OW'(push);
    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    head_d    = '0;
    if (occ_d != '0) begin
      head_d = (occ_rem == '0) ? {entry_sat, entry_len} : mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (g) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (s) begin
      state_q <= ACTIVE;
      busy_q  <= 1'b1;
      cnt_q   <= (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr_q] <= {entry_sat, entry_len};
    end
  end

  // FIFO control and registered head presentation
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      len_valid_q  <= 1'b0;
      len_data_q   <= '0;
      len_sat_q    <= 1'b0;
      full_q       <= 1'b0;
      drop_pulse_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      len_valid_q  <= (occ_d != '0);
      len_data_q   <= head_d[CNT_W-1:0];
      len_sat_q    <= head_d[CNT_W];
      full_q       <= (occ_d == OW'(DEPTH));
      drop_pulse_q <= g && !push;
    end
  end

`ifdef BURST_LEN_TALLY_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (g && !push && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign busy       = busy_q;
  assign len_valid  = len_valid_q;
  assign len_data   = len_data_q;
  assign len_sat    = len_sat_q;
  assign full       = full_q;
  assign drop_pulse = drop_pulse_q;

endmodule
